// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// hazard_fwd_unit : EX-stage forwarding selects, load-use stall, branch flush
// Revision 1.0
// ============================================================================
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_regwrite,
  input  logic              d_memread,
  input  logic              branch_taken_e,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_e_valid;
  logic [REG_AW-1:0] r_e_rs1;
  logic [REG_AW-1:0] r_e_rs2;
  logic              r_e_use_rs1;
  logic              r_e_use_rs2;
  logic [REG_AW-1:0] r_e_rd;
  logic              r_e_regwrite;
  logic              r_e_memread;

  // The MEM-stage load flag is not kept: a load in MEM never stalls ID.
  logic              r_m_valid;
  logic [REG_AW-1:0] r_m_rd;
  logic              r_m_regwrite;

  logic              r_w_valid;
  logic [REG_AW-1:0] r_w_rd;
  logic              r_w_regwrite;

  logic [CNT_W-1:0]  r_stall_count;

  logic w_m_writer;
  logic w_w_writer;
  logic w_e_writer;
  logic w_e_reads_a;
  logic w_e_reads_b;
  logic w_mm_a;
  logic w_mw_a;
  logic w_mm_b;
  logic w_mw_b;
  logic w_lu;

  // Only writers of a non-zero register can produce a hazard.
  assign w_m_writer  = r_m_valid && r_m_regwrite && (r_m_rd != '0);
  assign w_w_writer  = r_w_valid && r_w_regwrite && (r_w_rd != '0);
  assign w_e_writer  = r_e_valid && r_e_regwrite && (r_e_rd != '0);
  assign w_e_reads_a = r_e_valid && r_e_use_rs1;
  assign w_e_reads_b = r_e_valid && r_e_use_rs2;

  assign w_mm_a = w_m_writer && w_e_reads_a && (r_m_rd == r_e_rs1);
  assign w_mw_a = w_w_writer && w_e_reads_a && (r_w_rd == r_e_rs1);
  assign w_mm_b = w_m_writer && w_e_reads_b && (r_m_rd == r_e_rs2);
  assign w_mw_b = w_w_writer && w_e_reads_b && (r_w_rd == r_e_rs2);

  assign forward_a = {w_mw_a, w_mm_a};
  assign forward_b = {w_mw_b, w_mm_b};

  assign w_lu = w_e_writer && r_e_memread && d_valid &&
                ((d_use_rs1 && (d_rs1 == r_e_rd)) ||
                 (d_use_rs2 && (d_rs2 == r_e_rd)));

  // A taken branch squashes the ID instruction, so it overrides a load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (w_lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid     <= 1'b0;
      r_e_rs1       <= '0;
      r_e_rs2       <= '0;
      r_e_use_rs1   <= 1'b0;
      r_e_use_rs2   <= 1'b0;
      r_e_rd        <= '0;
      r_e_regwrite  <= 1'b0;
      r_e_memread   <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_rd        <= '0;
      r_m_regwrite  <= 1'b0;
      r_w_valid     <= 1'b0;
      r_w_rd        <= '0;
      r_w_regwrite  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_w_valid    <= r_m_valid;
      r_w_rd       <= r_m_rd;
      r_w_regwrite <= r_m_regwrite;

      r_m_valid    <= r_e_valid;
      r_m_rd       <= r_e_rd;
      r_m_regwrite <= r_e_regwrite;

      if (flush_e) begin
        r_e_valid    <= 1'b0;
        r_e_rs1      <= '0;
        r_e_rs2      <= '0;
        r_e_use_rs1  <= 1'b0;
        r_e_use_rs2  <= 1'b0;
        r_e_rd       <= '0;
        r_e_regwrite <= 1'b0;
        r_e_memread  <= 1'b0;
      end else begin
        r_e_valid    <= d_valid;
        r_e_rs1      <= d_rs1;
        r_e_rs2      <= d_rs2;
        r_e_use_rs1  <= d_use_rs1;
        r_e_use_rs2  <= d_use_rs2;
        r_e_rd       <= d_rd;
        r_e_regwrite <= d_regwrite;
        r_e_memread  <= d_memread;
      end

      if (w_lu && !branch_taken_e && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
